// File: rtl/frame_blitter.sv
// Rectangle-fill writer for a palette-indexed framebuffer: clips a command to the
// screen and streams one pixel write per cycle in raster order, optionally after screenEnd.
module frame_blitter #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter bit WAIT_FRAME = 1'b1
) (
  input  logic                  clk_25mHz,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [9:0]            cmd_x,
  input  logic [8:0]            cmd_y,
  input  logic [9:0]            cmd_w,
  input  logic [8:0]            cmd_h,
  input  logic [DATA_WIDTH-1:0] cmd_color,
  input  logic                  screenEnd,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  clipped
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL, S_DONE} state_t;

  localparam logic [10:0]           W11      = 11'(WIDTH);
  localparam logic [10:0]           H11      = 11'(HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(WIDTH);

  state_t                  state_q, state_d;
  logic [9:0]              x_start_q, x_start_d;
  logic [10:0]             x_end_q, x_end_d;
  logic [10:0]             y_end_q, y_end_d;
  logic [10:0]             cx_q, cx_d;
  logic [10:0]             cy_q, cy_d;
  logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    clipped_q, clipped_d;

  // Acceptance-time clipping in 11-bit arithmetic so x+w and y+h cannot overflow.
  logic [10:0]           x_sum, y_sum, cmd_x_end, cmd_y_end;
  logic                  cmd_empty, cmd_trim, accept;
  logic [ADDR_WIDTH-1:0] first_base;

  assign x_sum      = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign y_sum      = {2'b0, cmd_y} + {2'b0, cmd_h};
  assign cmd_x_end  = (x_sum > W11) ? W11 : x_sum;
  assign cmd_y_end  = (y_sum > H11) ? H11 : y_sum;
  assign cmd_empty  = (cmd_w == 10'd0) || (cmd_h == 9'd0) ||
                      ({1'b0, cmd_x} >= W11) || ({2'b0, cmd_y} >= H11);
  assign cmd_trim   = cmd_empty || (x_sum > W11) || (y_sum > H11);
  assign accept     = cmd_valid && cmd_ready_q;
  // The only multiply happens once per command; pixels then advance by +1 / +WIDTH.
  assign first_base = ROW_STEP * ADDR_WIDTH'(cmd_y);

  always_comb begin
    // NOTE: every _d gets a default hold value first so no path through the case infers a latch.
    state_d    = state_q;
    x_start_d  = x_start_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    row_base_d = row_base_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    clipped_d  = clipped_q;
    wr_en_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          clipped_d = cmd_trim;
          if (cmd_empty) begin
            state_d = S_DONE;
          end else begin
            x_start_d  = cmd_x;
            x_end_d    = cmd_x_end;
            y_end_d    = cmd_y_end;
            cx_d       = {1'b0, cmd_x};
            cy_d       = {2'b0, cmd_y};
            row_base_d = first_base;
            wr_addr_d  = first_base + ADDR_WIDTH'(cmd_x);
            wr_data_d  = cmd_color;
            if (WAIT_FRAME) begin
              state_d = S_WAIT;
            end else begin
              state_d = S_FILL;
              wr_en_d = 1'b1;
            end
          end
        end
      end
      S_WAIT: begin
        // wr_addr already holds the first pixel, so the first write follows the pulse directly.
        if (screenEnd) begin
          state_d = S_FILL;
          wr_en_d = 1'b1;
        end
      end
      S_FILL: begin
        if (cx_q + 11'd1 == x_end_q) begin
          if (cy_q + 11'd1 == y_end_q) begin
            state_d = S_DONE;
          end else begin
            cx_d       = {1'b0, x_start_q};
            cy_d       = cy_q + 11'd1;
            row_base_d = row_base_q + ROW_STEP;
            wr_addr_d  = row_base_q + ROW_STEP + ADDR_WIDTH'(x_start_q);
            wr_en_d    = 1'b1;
          end
        end else begin
          cx_d      = cx_q + 11'd1;
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          wr_en_d   = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      x_start_q   <= '0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      row_base_q  <= '0;
      cmd_ready_q <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clipped_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge _d values together.
      state_q     <= state_d;
      x_start_q   <= x_start_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      row_base_q  <= row_base_d;
      cmd_ready_q <= cmd_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clipped_q   <= clipped_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign clipped   = clipped_q;

endmodule

// File: tb/tb_frame_blitter.sv
// Self-checking bench for frame_blitter: one instance starts fills immediately, the other
// waits for screenEnd; expected write lists come from a plain nested-loop rectangle model.
module tb_frame_blitter;

  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int AW     = 19;
  localparam int DW     = 8;

  logic          clk_25mHz = 1'b0;
  logic          reset     = 1'b0;
  logic          cmd_valid0 = 1'b0, cmd_valid1 = 1'b0;
  logic [9:0]    cmd_x = '0;
  logic [8:0]    cmd_y = '0;
  logic [9:0]    cmd_w = '0;
  logic [8:0]    cmd_h = '0;
  logic [DW-1:0] cmd_color = '0;
  logic          screenEnd = 1'b0;

  logic          cmd_ready0, wr_en0, busy0, done0, clipped0;
  logic [AW-1:0] wr_addr0;
  logic [DW-1:0] wr_data0;
  logic          cmd_ready1, wr_en1, busy1, done1, clipped1;
  logic [AW-1:0] wr_addr1;
  logic [DW-1:0] wr_data1;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  exp_q[$];
  bit  exp_clip;
  bit  sel = 1'b0;

  always #5 clk_25mHz = ~clk_25mHz;

  frame_blitter #(.WAIT_FRAME(1'b0)) dut0 (
    .clk_25mHz(clk_25mHz), .reset(reset), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .screenEnd(screenEnd), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .done(done0), .clipped(clipped0));

  frame_blitter #(.WAIT_FRAME(1'b1)) dut1 (
    .clk_25mHz(clk_25mHz), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .screenEnd(screenEnd), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .done(done1), .clipped(clipped1));

  logic          o_ready, o_en, o_busy, o_done, o_clip;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  assign o_ready = sel ? cmd_ready1 : cmd_ready0;
  assign o_en    = sel ? wr_en1     : wr_en0;
  assign o_busy  = sel ? busy1      : busy0;
  assign o_done  = sel ? done1      : done0;
  assign o_clip  = sel ? clipped1   : clipped0;
  assign o_addr  = sel ? wr_addr1   : wr_addr0;
  assign o_data  = sel ? wr_data1   : wr_data0;

  // Reference: every on-screen pixel of the rectangle, raster order, as x + WIDTH*y.
  task automatic model_fill(input int x, input int y, input int w, input int h);
    exp_q.delete();
    for (int r = y; r < y + h && r < HEIGHT; r++)
      for (int c = x; c < x + w && c < WIDTH; c++)
        exp_q.push_back(c + WIDTH * r);
    exp_clip = (exp_q.size() == 0) || (exp_q.size() != w * h);
  endtask

  task automatic drive_fields(input int x, input int y, input int w, input int h, input int c);
    cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h); cmd_color = DW'(c);
  endtask

  // Watches n writes, the done pulse and the return of cmd_ready, counting from cycle 1 after the start edge.
  task automatic watch(input string name, input int n, input int color, input bit pulse_mid);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk_25mHz);
      cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
      screenEnd = pulse_mid && (k == 2);
      n_cmp++;
      if (o_en !== (k <= n)) begin
        n_bad++; $display("FAIL %s cyc%0d wr_en got %0b want %0b", name, k, o_en, k <= n);
      end
      if (k <= n) begin
        n_cmp += 2;
        if (o_addr !== AW'(exp_q[k-1])) begin
          n_bad++; $display("FAIL %s cyc%0d wr_addr got %0d want %0d", name, k, o_addr, exp_q[k-1]);
        end
        if (o_data !== DW'(color)) begin
          n_bad++; $display("FAIL %s cyc%0d wr_data got %0h want %0h", name, k, o_data, DW'(color));
        end
      end
      n_cmp += 3;
      if (o_done !== (k == n + 1)) begin
        n_bad++; $display("FAIL %s cyc%0d done got %0b want %0b", name, k, o_done, k == n + 1);
      end
      if (o_busy !== (k <= n + 1)) begin
        n_bad++; $display("FAIL %s cyc%0d busy got %0b want %0b", name, k, o_busy, k <= n + 1);
      end
      if (o_ready !== (k == n + 2)) begin
        n_bad++; $display("FAIL %s cyc%0d cmd_ready got %0b want %0b", name, k, o_ready, k == n + 2);
      end
    end
  endtask

  task automatic run_fill(input bit which, input int x, input int y, input int w, input int h,
                          input int c, input string name);
    sel = which;
    model_fill(x, y, w, h);
    @(negedge clk_25mHz);
    drive_fields(x, y, w, h, c);
    if (which) cmd_valid1 = 1'b1; else cmd_valid0 = 1'b1;
    watch(name, exp_q.size(), c, 1'b0);
    n_cmp++;
    if (o_clip !== exp_clip) begin
      n_bad++; $display("FAIL %s clipped got %0b want %0b", name, o_clip, exp_clip);
    end
  endtask

  task automatic test_reset;
    sel = 1'b0;
    #12;
    n_cmp += 4;
    if (cmd_ready0 !== 1'b1) begin n_bad++; $display("FAIL reset cmd_ready got %0b want 1", cmd_ready0); end
    if ({wr_en0, busy0, done0, clipped0} !== 4'b0) begin
      n_bad++; $display("FAIL reset en/busy/done/clip got %b want 0000", {wr_en0, busy0, done0, clipped0});
    end
    if (wr_addr0 !== '0 || wr_data0 !== '0) begin
      n_bad++; $display("FAIL reset addr/data got %0d/%0h want 0/0", wr_addr0, wr_data0);
    end
    if (cmd_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL reset dut1 ready/busy got %0b/%0b want 1/0", cmd_ready1, busy1);
    end
    @(negedge clk_25mHz);
    reset = 1'b1;
  endtask

  task automatic test_unclipped;
    run_fill(1'b0, 10, 20, 3, 2, 8'h05, "unclipped");
  endtask

  task automatic test_clip;
    run_fill(1'b0, 638, 479, 5, 4, 8'h9A, "clip_br");
  endtask

  task automatic test_empty;
    run_fill(1'b0, 5, 5, 0, 3, 8'h11, "empty_w0");
    run_fill(1'b0, 700, 10, 4, 4, 8'h12, "empty_x700");
    run_fill(1'b0, 3, 480, 4, 4, 8'h13, "empty_y480");
    run_fill(1'b1, 5, 5, 4, 0, 8'h14, "empty_wait_h0");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      int x, y, w, h;
      x = $urandom_range(0, 700);
      y = $urandom_range(0, 490);
      w = $urandom_range(0, 12);
      h = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom_range(620, 639);
        w = 1023;
      end
      run_fill(1'b0, x, y, w, h, $urandom_range(0, 151), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_frame_wait;
    sel = 1'b1;
    model_fill(100, 200, 4, 3);
    @(negedge clk_25mHz);
    drive_fields(100, 200, 4, 3, 8'h3C);
    cmd_valid1 = 1'b1;
    screenEnd  = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk_25mHz);
      cmd_valid1 = 1'b0;
      screenEnd  = 1'b0;
      drive_fields($urandom_range(0, 600), 7, 2, 2, 8'hFF);
      n_cmp++;
      if (wr_en1 !== 1'b0) begin n_bad++; $display("FAIL frame_wait cyc%0d wr_en got %0b want 0", i, wr_en1); end
      if (i == 1 || i == 50) begin
        n_cmp++;
        if (busy1 !== 1'b1 || cmd_ready1 !== 1'b0) begin
          n_bad++; $display("FAIL frame_wait cyc%0d busy/ready got %0b/%0b want 1/0", i, busy1, cmd_ready1);
        end
      end
    end
    screenEnd = 1'b1;
    watch("frame_wait_fill", exp_q.size(), 8'h3C, 1'b1);
    n_cmp++;
    if (clipped1 !== 1'b0) begin n_bad++; $display("FAIL frame_wait clipped got %0b want 0", clipped1); end
  endtask

  task automatic test_back_to_back;
    int a_q[$];
    int b_q[$];
    bit e_en, e_done, e_ready;
    int e_addr, e_data;
    sel = 1'b0;
    model_fill(50, 60, 4, 1); a_q = exp_q;
    model_fill(0, 0, 2, 1);   b_q = exp_q;
    @(negedge clk_25mHz);
    drive_fields(50, 60, 4, 1, 8'h21);
    cmd_valid0 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_25mHz);
      e_en    = (k <= 4) || (k == 7) || (k == 8);
      e_addr  = (k <= 4) ? a_q[k-1] : ((k == 7 || k == 8) ? b_q[k-7] : 0);
      e_data  = (k <= 4) ? 8'h21 : 8'h22;
      e_done  = (k == 5) || (k == 9);
      e_ready = (k == 6) || (k == 10);
      n_cmp += 3;
      if (wr_en0 !== e_en) begin n_bad++; $display("FAIL b2b cyc%0d wr_en got %0b want %0b", k, wr_en0, e_en); end
      if (done0 !== e_done) begin n_bad++; $display("FAIL b2b cyc%0d done got %0b want %0b", k, done0, e_done); end
      if (cmd_ready0 !== e_ready) begin
        n_bad++; $display("FAIL b2b cyc%0d cmd_ready got %0b want %0b", k, cmd_ready0, e_ready);
      end
      if (e_en) begin
        n_cmp++;
        if (wr_addr0 !== AW'(e_addr) || wr_data0 !== DW'(e_data)) begin
          n_bad++; $display("FAIL b2b cyc%0d addr/data got %0d/%0h want %0d/%0h", k, wr_addr0, wr_data0, e_addr, e_data);
        end
      end
      if (k < 6) drive_fields($urandom_range(0, 639), $urandom_range(0, 479), 9, 3, $urandom_range(0, 255));
      else if (k == 6) drive_fields(0, 0, 2, 1, 8'h22);
      else if (k == 7) cmd_valid0 = 1'b0;
    end
  endtask

  task automatic test_reset_midfill;
    sel = 1'b0;
    @(negedge clk_25mHz);
    drive_fields(0, 0, 10, 1, 8'h07);
    cmd_valid0 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_25mHz);
      cmd_valid0 = 1'b0;
      n_cmp++;
      if (wr_en0 !== 1'b1 || wr_addr0 !== AW'(k - 1)) begin
        n_bad++; $display("FAIL rst_mid cyc%0d en/addr got %0b/%0d want 1/%0d", k, wr_en0, wr_addr0, k - 1);
      end
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if ({wr_en0, busy0, done0, cmd_ready0} !== 4'b0001) begin
      n_bad++; $display("FAIL rst_mid async en/busy/done/ready got %b want 0001", {wr_en0, busy0, done0, cmd_ready0});
    end
    @(negedge clk_25mHz);
    reset = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk_25mHz);
      n_cmp++;
      if (wr_en0 !== 1'b0 || done0 !== 1'b0 || cmd_ready0 !== 1'b1) begin
        n_bad++; $display("FAIL rst_mid after cyc%0d en/done/ready got %0b/%0b/%0b want 0/0/1", k, wr_en0, done0, cmd_ready0);
      end
    end
    run_fill(1'b0, 600, 100, 2, 2, 8'h44, "post_reset");
  endtask

  initial begin
    test_reset();
    test_unclipped();
    test_clip();
    test_empty();
    test_random();
    test_frame_wait();
    test_back_to_back();
    test_reset_midfill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
